liteic_rr_arbiter: RTL and testbench
====================================

Name: liteic_rr_arbiter

Overview:
- Round-robin arbiter for the lite interconnect; sits directly upstream of the interconnect's priority-encoder / address-mux stage.
- Takes per-master request lines and produces a registered one-hot grant plus a binary index. The grant is locked for the whole transaction and released on a completion pulse from the slave side.
- Downstream mux and decode consume `grant_o` and `grant_idx_o` directly.

Parameters:
- `N_MASTERS`, 4: number of requesting masters, 2..32.
- `IDX_W`, `$clog2(N_MASTERS)`: width of the binary grant index.
- `TIMEOUT_CYCLES`, 256: grant watchdog limit in cycles, ≥2. Used only with `LITEIC_ARB_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `req_i`  in  `N_MASTERS`  per-master request, level, bit i = master i.
- `done_i`  in  1  single-cycle transaction-complete pulse for the current grant holder.
- `grant_o`  out  `N_MASTERS`  registered one-hot grant; all zero when idle.
- `grant_idx_o`  out  `IDX_W`  binary index of the set `grant_o` bit; 0 when idle.
- `grant_valid_o`  out  1  high while a grant is held (`|grant_o`).
- `timeout_o`  out  1  one-cycle pulse when the watchdog forces a release.

Behaviour:
- Reset (`rst_n` low, asynchronous):
  - `grant_o`=0, `grant_idx_o`=0, `grant_valid_o`=0, `timeout_o`=0.
  - state=IDLE, `last_idx`=`N_MASTERS`-1, so the first arbitration favours master 0.
- Arbitration function, combinational:
  - `mask` = bits with index strictly greater than `last_idx`.
  - If `req_i & mask` is nonzero, select its lowest set bit. Otherwise select the lowest set bit of `req_i`.
  - Result is exactly one-hot, or zero if `req_i`=0.
- State IDLE:
  - If `req_i`≠0: at the next edge load `grant_o`/`grant_idx_o` with the winner, set `last_idx`=winner, go BUSY.
  - Latency from request to grant is 1 cycle.
  - `done_i` in IDLE is ignored.
- State BUSY:
  - Grant is held constant regardless of `req_i` changes, including the holder deasserting its request. No early release.
  - On `done_i`=1, arbitrate in the same cycle with `last_idx` = current holder:
    - winner exists: load the new grant at the next edge and stay BUSY. This is zero-bubble back-to-back.
    - no requests: clear the grant and go IDLE.
  - The finishing master may win again only if no other master is requesting.
- `last_idx` updates only when a grant is loaded. It is unchanged by release to IDLE.
- Reset asserted mid-transaction: grant drops immediately (asynchronous). After release, arbitration restarts from master 0.
- `N_MASTERS`=1 boundary is not supported (minimum 2). `IDX_W` holds every index 0..`N_MASTERS`-1.
- All outputs are registered. There is no combinational path from `req_i`/`done_i` to any output.

Optional Feature:
- `LITEIC_ARB_TIMEOUT_EN` defined:
  - An `$clog2(TIMEOUT_CYCLES)`-bit counter clears on every grant load and increments each BUSY cycle.
  - When it reaches `TIMEOUT_CYCLES`-1 with `done_i` low, that cycle is treated exactly as `done_i`=1 (re-arbitrate or go IDLE).
  - `timeout_o` pulses high for one cycle, coincident with the resulting grant change.
  - `done_i` on the same cycle takes precedence: normal release, no `timeout_o`.
- Not defined: no counter is present, `timeout_o` is tied 0, and a grant is held indefinitely until `done_i`.

Test Plan (`N_MASTERS`=4):
1. Reset then `req_i`=0001 at cycle 0 → cycle 1 `grant_o`=0001, `idx`=0, `valid`=1. Drop `req_i` at cycle 2 → grant held. `done_i` at cycle 5 → cycle 6 `grant_o`=0000, `valid`=0.
2. `req_i`=1111 constant, `done_i` pulsed every 2nd cycle → grant index sequence 0,1,2,3,0 with no idle cycle between grants.
3. Holder idx 2, `req_i`=1011, `done_i` → next grant idx 3. Then `req_i`=0011, `done_i` → grant idx 0 (wrap). Then `req_i`=0001, `done_i` → idx 0 again (sole requester).
4. `done_i` pulsed while IDLE with `req_i`=0 → outputs stay 0, next `req_i`=0100 → `grant_o`=0100 after one cycle.
5. `rst_n` pulled low asynchronously mid-BUSY, between clock edges → `grant_o`/`valid` go 0 before the next edge. After release with `req_i`=1010 → grant idx 1.
6. `LITEIC_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8:
   - `req_i`=0011, no `done_i` → `timeout_o` high on the 8th BUSY cycle, grant moves 0→1 at the same time.
   - Repeat with `done_i` on that exact cycle → `timeout_o` stays 0.

Source files
------------

// File: rtl/liteic_rr_arbiter.sv
// Round-robin arbiter for the lite interconnect: registered one-hot grant, locked until done_i.
// Optional grant watchdog is enabled by defining LITEIC_ARB_TIMEOUT_EN.
module liteic_rr_arbiter #(
    parameter int N_MASTERS      = 4,
    parameter int IDX_W          = $clog2(N_MASTERS),
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_MASTERS-1:0] req_i,
    input  logic                 done_i,
    output logic [N_MASTERS-1:0] grant_o,
    output logic [IDX_W-1:0]     grant_idx_o,
    output logic                 grant_valid_o,
    output logic                 timeout_o
);

    typedef enum logic {S_IDLE, S_BUSY} state_e;

    state_e               state_q;
    logic [N_MASTERS-1:0] grant_q;
    logic [IDX_W-1:0]     idx_q;
    logic [IDX_W-1:0]     last_idx_q;
    logic                 valid_q;
    logic                 timeout_q;

    logic [N_MASTERS-1:0] win_oh;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_vld;
    logic                 tmo_hit;
    logic                 rel;
    logic                 load;

    // Configurations with fewer than two masters or a watchdog below two cycles are unsupported.
    if (N_MASTERS < 2 || TIMEOUT_CYCLES < 2) begin : g_unsupported_cfg
    end

    // Masters above the last winner get first pick; otherwise wrap to the lowest requester.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (!win_vld && req_i[i] && (i > int'(last_idx_q))) begin
                win_oh[i] = 1'b1;
                win_idx   = IDX_W'(i);
                win_vld   = 1'b1;
            end
        end
        for (int i = 0; i < N_MASTERS; i++) begin
            if (!win_vld && req_i[i]) begin
                win_oh[i] = 1'b1;
                win_idx   = IDX_W'(i);
                win_vld   = 1'b1;
            end
        end
    end

`ifdef LITEIC_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // done_i in the limit cycle wins, so the watchdog only fires when done_i is low.
    assign tmo_hit = (state_q == S_BUSY) && !done_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (load)                    cnt_d = '0;
        else if (state_q == S_BUSY)  cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign rel  = (state_q == S_BUSY) && (done_i || tmo_hit);
    assign load = win_vld && ((state_q == S_IDLE) || rel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            grant_q    <= '0;
            idx_q      <= '0;
            valid_q    <= 1'b0;
            timeout_q  <= 1'b0;
            last_idx_q <= IDX_W'(N_MASTERS - 1);
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (win_vld) begin
                        grant_q    <= win_oh;
                        idx_q      <= win_idx;
                        valid_q    <= 1'b1;
                        last_idx_q <= win_idx;
                        state_q    <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (rel) begin
                        timeout_q <= tmo_hit;
                        if (win_vld) begin
                            grant_q    <= win_oh;
                            idx_q      <= win_idx;
                            last_idx_q <= win_idx;
                        end else begin
                            // last_idx_q is kept so the next grant continues the rotation.
                            grant_q <= '0;
                            idx_q   <= '0;
                            valid_q <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign grant_o       = grant_q;
    assign grant_idx_o   = idx_q;
    assign grant_valid_o = valid_q;
    assign timeout_o     = timeout_q;

endmodule

// File: tb/tb_liteic_rr_arbiter.sv
// Directed bench for liteic_rr_arbiter (4 masters, 8-cycle watchdog when enabled).
module tb_liteic_rr_arbiter;
    localparam int N  = 4;
    localparam int IW = 2;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b1;
    logic [N-1:0]  req_i  = '0;
    logic          done_i = 1'b0;
    logic [N-1:0]  grant_o;
    logic [IW-1:0] grant_idx_o;
    logic          grant_valid_o;
    logic          timeout_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string        tag;
        logic [N-1:0] g;
        logic         t;
    } exp_t;
    exp_t sb[$];

    liteic_rr_arbiter #(.N_MASTERS(N), .IDX_W(IW), .TIMEOUT_CYCLES(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_i        (req_i),
        .done_i       (done_i),
        .grant_o      (grant_o),
        .grant_idx_o  (grant_idx_o),
        .grant_valid_o(grant_valid_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] oh2idx(input logic [N-1:0] oh);
        logic [IW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) if (oh[i]) r = IW'(i);
        return r;
    endfunction

    task automatic chk_now(input string tag, input logic [N-1:0] g, input logic t);
        logic [IW-1:0] ei;
        logic          ev;
        ei = oh2idx(g);
        ev = |g;
        checks++;
        assert (grant_o === g) else begin
            errors++;
            $error("FAIL %s grant_o got %b exp %b", tag, grant_o, g);
        end
        checks++;
        assert (grant_idx_o === ei) else begin
            errors++;
            $error("FAIL %s grant_idx_o got %0d exp %0d", tag, grant_idx_o, ei);
        end
        checks++;
        assert (grant_valid_o === ev) else begin
            errors++;
            $error("FAIL %s grant_valid_o got %b exp %b", tag, grant_valid_o, ev);
        end
        checks++;
        assert (timeout_o === t) else begin
            errors++;
            $error("FAIL %s timeout_o got %b exp %b", tag, timeout_o, t);
        end
    endtask

    // Drive one cycle of stimulus, queue the expected post-edge outputs, then compare.
    task automatic cyc(input logic [N-1:0] r, input logic d, input logic [N-1:0] g,
                       input logic t, input string tag);
        exp_t e;
        req_i  = r;
        done_i = d;
        e.tag = tag; e.g = g; e.t = t;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk_now(e.tag, e.g, e.t);
        done_i = 1'b0;
    endtask

    task automatic do_reset();
        req_i  = '0;
        done_i = 1'b0;
        rst_n  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        #1 rst_n = 1'b0;
        #2 chk_now("reset", 4'b0000, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // 1: single master, grant held after request drops, release on done
        cyc(4'b0001, 1'b0, 4'b0001, 1'b0, "t1_grant");
        cyc(4'b0001, 1'b0, 4'b0001, 1'b0, "t1_hold");
        cyc(4'b0000, 1'b0, 4'b0001, 1'b0, "t1_drop_c2");
        cyc(4'b0000, 1'b0, 4'b0001, 1'b0, "t1_drop_c3");
        cyc(4'b0000, 1'b0, 4'b0001, 1'b0, "t1_drop_c4");
        cyc(4'b0000, 1'b1, 4'b0000, 1'b0, "t1_release");

        // 2: all requesting, done every 2nd cycle, zero-bubble rotation 0,1,2,3,0
        do_reset();
        cyc(4'b1111, 1'b0, 4'b0001, 1'b0, "t2_g0");
        cyc(4'b1111, 1'b1, 4'b0010, 1'b0, "t2_g1");
        cyc(4'b1111, 1'b0, 4'b0010, 1'b0, "t2_h1");
        cyc(4'b1111, 1'b1, 4'b0100, 1'b0, "t2_g2");
        cyc(4'b1111, 1'b0, 4'b0100, 1'b0, "t2_h2");
        cyc(4'b1111, 1'b1, 4'b1000, 1'b0, "t2_g3");
        cyc(4'b1111, 1'b0, 4'b1000, 1'b0, "t2_h3");
        cyc(4'b1111, 1'b1, 4'b0001, 1'b0, "t2_wrap0");
        cyc(4'b0000, 1'b1, 4'b0000, 1'b0, "t2_idle");

        // 3: skip non-requesters, wrap, sole requester re-wins
        cyc(4'b0100, 1'b0, 4'b0100, 1'b0, "t3_g2");
        cyc(4'b1011, 1'b1, 4'b1000, 1'b0, "t3_g3");
        cyc(4'b0011, 1'b1, 4'b0001, 1'b0, "t3_wrap0");
        cyc(4'b0001, 1'b1, 4'b0001, 1'b0, "t3_sole0");
        cyc(4'b0000, 1'b1, 4'b0000, 1'b0, "t3_idle");

        // 4: done ignored in IDLE, then one-cycle grant latency
        cyc(4'b0000, 1'b1, 4'b0000, 1'b0, "t4_idle_done_a");
        cyc(4'b0000, 1'b1, 4'b0000, 1'b0, "t4_idle_done_b");
        cyc(4'b0100, 1'b0, 4'b0100, 1'b0, "t4_g2");
        cyc(4'b0000, 1'b1, 4'b0000, 1'b0, "t4_idle");
        // pointer survives release to IDLE: after master 2, master 3 beats master 0
        cyc(4'b1001, 1'b0, 4'b1000, 1'b0, "t4_last_kept");
        cyc(4'b0000, 1'b1, 4'b0000, 1'b0, "t4_idle2");

        // 5: asynchronous reset mid-BUSY, then restart from master 0
        cyc(4'b0010, 1'b0, 4'b0010, 1'b0, "t5_g1");
        cyc(4'b0010, 1'b0, 4'b0010, 1'b0, "t5_hold");
        #2 rst_n = 1'b0;
        #1 chk_now("t5_async_rst", 4'b0000, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(4'b1010, 1'b0, 4'b0010, 1'b0, "t5_restart_g1");
        cyc(4'b0000, 1'b1, 4'b0000, 1'b0, "t5_idle");

`ifdef LITEIC_ARB_TIMEOUT_EN
        // 6: watchdog forces 0->1 after 8 BUSY cycles; done on the limit cycle suppresses timeout_o
        cyc(4'b0011, 1'b0, 4'b0001, 1'b0, "t6_g0");
        for (int k = 1; k <= 7; k++) cyc(4'b0011, 1'b0, 4'b0001, 1'b0, "t6_busy");
        cyc(4'b0011, 1'b0, 4'b0010, 1'b1, "t6_timeout");
        cyc(4'b0011, 1'b0, 4'b0010, 1'b0, "t6_pulse_end");
        for (int k = 2; k <= 7; k++) cyc(4'b0011, 1'b0, 4'b0010, 1'b0, "t6_busy2");
        cyc(4'b0011, 1'b1, 4'b0001, 1'b0, "t6_done_wins");
        cyc(4'b0000, 1'b1, 4'b0000, 1'b0, "t6_idle");
`else
        // 6: without the watchdog a grant is held indefinitely
        cyc(4'b0011, 1'b0, 4'b0001, 1'b0, "t6_g0");
        for (int k = 1; k <= 12; k++) cyc(4'b0011, 1'b0, 4'b0001, 1'b0, "t6_no_tmo");
        cyc(4'b0011, 1'b1, 4'b0010, 1'b0, "t6_done");
        cyc(4'b0000, 1'b1, 4'b0000, 1'b0, "t6_idle");
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
